// File: rtl/uart_pkg.sv
// Types and constants shared between the UART transmitter and receiver.
// Frame: start bit, 8 data bits LSB first, parity bit, stop bit.
package uart_pkg;

    localparam int FRAME_BITS = 11;
    localparam int DATA_BITS  = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } uart_state_t;

    function automatic logic parity_bit(input logic [DATA_BITS-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_baud_timer.sv
// Bit-period counter: tick is high on the last of every BAUD_CLOCK_CYCLES cycles.
// clear restarts the period; no backpressure, free-running otherwise.
module uart_baud_timer #(
    parameter int BAUD_CLOCK_CYCLES = 5208
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (BAUD_CLOCK_CYCLES > 1) ? $clog2(BAUD_CLOCK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BAUD_CLOCK_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;

    assign tick = (cnt_q == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clear || tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: accepts din when idle and send=1; tx_out goes low the next cycle.
// Frame lasts 11 bit periods, done pulses in the first idle cycle; send is ignored while busy.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQUENCY = 100_000_000,
    parameter int BAUD_RATE     = 19_200,
    parameter int PARITY        = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 send,
    input  logic [DATA_BITS-1:0] din,
    output logic                 busy,
    output logic                 done,
    output logic                 tx_out
);

    localparam int BAUD_CLOCK_CYCLES = CLK_FREQUENCY / BAUD_RATE;
    localparam logic PARITY_ODD = (PARITY != 0);

    uart_state_t          state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic                 par_q, par_d;
    logic                 tx_d, busy_d, done_d;
    logic                 tick, clear;

    uart_baud_timer #(
        .BAUD_CLOCK_CYCLES(BAUD_CLOCK_CYCLES)
    ) u_baud (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .tick  (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_idx_q <= '0;
            par_q     <= 1'b0;
            tx_out    <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            par_q     <= par_d;
            tx_out    <= tx_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

    // tx_d is the line value for the next cycle, so every bit change lands on a tick edge.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        par_d     = par_q;
        tx_d      = tx_out;
        busy_d    = 1'b1;
        done_d    = 1'b0;
        clear     = 1'b0;

        unique case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (send) begin
                    state_d = START;
                    shift_d = din;
                    par_d   = parity_bit(din, PARITY_ODD);
                    clear   = 1'b1;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            START: begin
                if (tick) begin
                    state_d   = DATA;
                    bit_idx_d = '0;
                    tx_d      = shift_q[0];
                    clear     = 1'b1;
                end
            end
            DATA: begin
                if (tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == 3'd7) begin
                        state_d   = PAR;
                        bit_idx_d = '0;
                        tx_d      = par_q;
                        clear     = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = shift_q[1];
                    end
                end
            end
            PAR: begin
                if (tick) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                    clear   = 1'b1;
                end
            end
            STOP: begin
                if (tick) begin
                    state_d = IDLE;
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    clear   = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: default-rate instance checked cycle by cycle, plus fast odd/even
// instances checked through a receiver model against a scoreboard queue.
module tb_uart_tx;

    localparam int SB = 8;      // 800 kHz / 100 kbit/s
    localparam int DB = 5208;   // 100 MHz / 19200 bit/s

    typedef struct {
        logic [7:0] d;
        logic       p;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_d = 1'b1, send_d = 1'b0;
    logic [7:0] din_d = '0;
    logic       busy_d, done_d, tx_d;

    logic       rst_s = 1'b1, send_o = 1'b0, send_e = 1'b0;
    logic [7:0] din_o = '0, din_e = '0;
    logic       busy_o, done_o, tx_o, busy_e, done_e, tx_e;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt_o = 0;
    int done_cnt_e = 0;
    exp_t exp_q[$];

    uart_tx u_dflt (
        .clk(clk), .rst(rst_d), .send(send_d), .din(din_d),
        .busy(busy_d), .done(done_d), .tx_out(tx_d)
    );

    uart_tx #(.CLK_FREQUENCY(800_000), .BAUD_RATE(100_000), .PARITY(1)) u_odd (
        .clk(clk), .rst(rst_s), .send(send_o), .din(din_o),
        .busy(busy_o), .done(done_o), .tx_out(tx_o)
    );

    uart_tx #(.CLK_FREQUENCY(800_000), .BAUD_RATE(100_000), .PARITY(0)) u_even (
        .clk(clk), .rst(rst_s), .send(send_e), .din(din_e),
        .busy(busy_e), .done(done_e), .tx_out(tx_e)
    );

    always @(negedge clk) begin
        if (done_o) done_cnt_o <= done_cnt_o + 1;
        if (done_e) done_cnt_e <= done_cnt_e + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    function automatic logic line_of(input int w);
        return (w == 0) ? tx_o : tx_e;
    endfunction

    function automatic logic busy_of(input int w);
        return (w == 0) ? busy_o : busy_e;
    endfunction

    function automatic logic fbit(input logic [7:0] d, input logic p, input int k);
        if (k == 0) return 1'b0;
        if (k == 9) return p;
        if (k == 10) return 1'b1;
        return d[k-1];
    endfunction

    task automatic push_exp(input int w, input logic [7:0] d);
        exp_t e;
        e.d = d;
        e.p = (^d) ^ (w == 0);
        exp_q.push_back(e);
    endtask

    task automatic send_byte(input int w, input logic [7:0] d);
        int n = 0;
        @(negedge clk);
        while (busy_of(w) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) check("send_wait_idle", 32'd1, 32'd0);
        if (w == 0) begin send_o = 1'b1; din_o = d; end
        else        begin send_e = 1'b1; din_e = d; end
        push_exp(w, d);
        @(negedge clk);
        send_o = 1'b0;
        send_e = 1'b0;
    endtask

    // Receiver model: find the start edge, sample each bit at its middle.
    task automatic rx_frame(input int w, output logic [7:0] d, output logic p, output logic ok);
        bit   found = 1'b0;
        logic st, sp;
        d = '0; p = 1'b0; ok = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            if (line_of(w) == 1'b0) found = 1'b1;
        end
        if (found) begin
            repeat (SB/2) @(negedge clk);
            st = line_of(w);
            for (int i = 0; i < 8; i++) begin
                repeat (SB) @(negedge clk);
                d[i] = line_of(w);
            end
            repeat (SB) @(negedge clk);
            p = line_of(w);
            repeat (SB) @(negedge clk);
            sp = line_of(w);
            ok = (st == 1'b0) && (sp == 1'b1);
        end
    endtask

    task automatic rx_check(input int w, input string tag);
        logic [7:0] d;
        logic       p, ok;
        exp_t       e;
        rx_frame(w, d, p, ok);
        if (exp_q.size() == 0) begin
            check({tag, "_noexp"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_data"}, 32'(d), 32'(e.d));
            check({tag, "_par"}, 32'(p), 32'(e.p));
            check({tag, "_err"}, 32'(!ok), 32'd0);
        end
    endtask

    task automatic run_default();
        int   errs = 0, dn = 0, done_at = -1, first_bad = -1;
        logic want;
        logic [7:0] d = 8'h41;
        logic p = (^d) ^ 1'b1;
        repeat (3) @(negedge clk);
        check("dflt_rst_tx", 32'(tx_d), 32'd1);
        check("dflt_rst_busy", 32'(busy_d), 32'd0);
        check("dflt_rst_done", 32'(done_d), 32'd0);
        rst_d = 1'b0;
        @(negedge clk);
        send_d = 1'b1;
        din_d  = d;
        @(negedge clk);
        send_d = 1'b0;
        din_d  = 8'h00;
        for (int c = 0; c <= 11*DB + 2; c++) begin
            if (c > 0) @(negedge clk);
            want = (c < 11*DB) ? fbit(d, p, c / DB) : 1'b1;
            if (tx_d !== want || busy_d !== (c < 11*DB)) begin
                errs++;
                if (first_bad < 0) first_bad = c;
            end
            if (done_d) begin
                dn++;
                done_at = c;
            end
        end
        check("dflt_line_errs", 32'(errs), 32'd0);
        if (errs != 0) $display("  first bad cycle %0d", first_bad);
        check("dflt_done_cnt", 32'(dn), 32'd1);
        check("dflt_done_cycle", 32'(done_at), 32'd57288);
    endtask

    task automatic run_small();
        int base, lows, n;
        repeat (3) @(negedge clk);
        check("rst_tx_odd", 32'(tx_o), 32'd1);
        check("rst_busy_odd", 32'(busy_o), 32'd0);
        check("rst_done_odd", 32'(done_o), 32'd0);
        check("rst_tx_even", 32'(tx_e), 32'd1);
        rst_s = 1'b0;

        send_byte(0, 8'h07); rx_check(0, "par07_odd");
        send_byte(0, 8'hFF); rx_check(0, "parFF_odd");
        send_byte(1, 8'hFF); rx_check(1, "parFF_even");
        send_byte(1, 8'h00); rx_check(1, "par00_even");
        repeat (2*SB) @(negedge clk);
        check("done_cnt_odd", 32'(done_cnt_o), 32'd2);
        check("done_cnt_even", 32'(done_cnt_e), 32'd2);

        // Changes on send/din mid-frame must not disturb the captured byte.
        base = done_cnt_o;
        send_byte(0, 8'hC3);
        fork
            rx_check(0, "busy_ign");
            begin
                repeat (20) @(negedge clk);
                din_o = 8'h00; send_o = 1'b1;
                @(negedge clk); send_o = 1'b0;
                repeat (30) @(negedge clk);
                send_o = 1'b1;
                @(negedge clk); send_o = 1'b0;
            end
        join
        repeat (SB) @(negedge clk);
        lows = 0;
        for (int i = 0; i < 3*SB; i++) begin
            @(negedge clk);
            if (!tx_o || busy_o) lows++;
        end
        check("busy_ign_no_2nd", 32'(lows), 32'd0);
        check("busy_ign_done", 32'(done_cnt_o - base), 32'd1);

        base = done_cnt_o;
        fork
            begin
                rx_check(0, "b2b_1");
                rx_check(0, "b2b_2");
            end
            begin
                send_o = 1'b1; din_o = 8'hA5; push_exp(0, 8'hA5);
                @(negedge clk);
                din_o = 8'h3C; push_exp(0, 8'h3C);
                n = 0;
                while (!done_o && n < 200) begin
                    @(negedge clk);
                    n++;
                end
                check("b2b_done_seen", 32'(done_o), 32'd1);
                @(negedge clk);
                send_o = 1'b0;
                check("b2b_no_gap_tx", 32'(tx_o), 32'd0);
                check("b2b_no_gap_busy", 32'(busy_o), 32'd1);
            end
        join
        repeat (2*SB) @(negedge clk);
        check("b2b_done_cnt", 32'(done_cnt_o - base), 32'd2);

        // Abort during data bit 3; outputs must drop before the next clock edge.
        send_o = 1'b1; din_o = 8'h96;
        @(negedge clk);
        send_o = 1'b0;
        repeat (4*SB + 2) @(negedge clk);
        check("pre_rst_busy", 32'(busy_o), 32'd1);
        #2 rst_s = 1'b1;
        #1;
        check("mid_rst_tx", 32'(tx_o), 32'd1);
        check("mid_rst_busy", 32'(busy_o), 32'd0);
        check("mid_rst_done", 32'(done_o), 32'd0);
        @(negedge clk);
        rst_s = 1'b0;
        lows = 0;
        for (int i = 0; i < 2*SB; i++) begin
            @(negedge clk);
            if (!tx_o || busy_o || done_o) lows++;
        end
        check("post_rst_idle", 32'(lows), 32'd0);
        send_byte(0, 8'h55); rx_check(0, "post_rst_55");

        for (int i = 0; i < 256; i++) begin
            send_byte(0, 8'($urandom));
            rx_check(0, "loop");
        end
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        fork
            run_default();
            run_small();
        join
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter CLK_FREQUENCY, default 100_000_000, is the clk frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 19_200, is the line bit rate in bits/s.
REQ-003 Parameter PARITY, default 1: 1 = odd parity, 0 = even parity.
REQ-004 clk  input  1  system clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 send  input  1  request to transmit din; sampled only in IDLE.
REQ-007 din  input  8  byte to transmit; captured on the accepting edge.
REQ-008 busy  output  1  high while a frame is in progress.
REQ-009 done  output  1  one-cycle pulse when a frame's stop bit completes.
REQ-010 tx_out  output  1  serial line; idles high; driven from a flop (glitch-free).

Function
REQ-011 Frame SHALL be: start bit (0), din[0..7] LSB first, parity bit, stop bit (1) = 11 bits.
REQ-012 BAUD_CLOCK_CYCLES SHALL equal CLK_FREQUENCY/BAUD_RATE (integer divide); default 5208.
REQ-013 Each bit SHALL be held on tx_out for exactly BAUD_CLOCK_CYCLES clk cycles; frame = 11*BAUD_CLOCK_CYCLES cycles.
REQ-014 Parity bit SHALL equal XOR of the 8 captured data bits XOR PARITY.
REQ-015 FSM states SHALL be IDLE, START, DATA, PAR, STOP.
REQ-016 IDLE: tx_out=1, busy=0; on edge with send=1, capture din into shift register, go to START.
REQ-017 Latency: tx_out=0 and busy=1 from the first cycle after the accepting edge.
REQ-018 START->DATA, DATA->PAR (after 8th bit), PAR->STOP, STOP->IDLE, each on baud counter terminal count.
REQ-019 3-bit bit index SHALL count 0..7 in DATA and reset to 0 on leaving DATA.
REQ-020 Baud counter SHALL reload to 0 on every state transition and on frame acceptance.
REQ-021 done SHALL pulse high for exactly one cycle, in the first IDLE cycle after STOP; busy=0 in that same cycle.
REQ-022 send and din changes while busy=1 SHALL be ignored; transmitted byte is the captured one.
REQ-023 If send=1 in the done cycle, the next frame SHALL be accepted on that edge (back-to-back; no extra idle bit beyond stop).
REQ-024 send held high continuously SHALL produce back-to-back frames, each sending din as sampled at its accepting edge.

Reset
REQ-025 rst=1 SHALL asynchronously force state=IDLE, tx_out=1, busy=0, done=0, counters and shift register to 0.
REQ-026 rst asserted mid-frame SHALL abort the frame immediately; line returns high with no partial stop bit.
REQ-027 First accept after rst deassertion SHALL require a rising clk edge with send=1 and rst=0.

Structure
REQ-028 Package uart_pkg SHALL hold the state enum type, FRAME_BITS=11 and DATA_BITS=8 constants, shared with the receiver side.
REQ-029 Baud timing SHALL be a sub-module uart_baud_timer (inputs clk, rst, clear; output tick at terminal count), parameterised by BAUD_CLOCK_CYCLES.
REQ-030 tx_out, busy, done SHALL be registered outputs; no combinational path from inputs to outputs.

Verification
REQ-031 Reset mid-frame: rst pulse during DATA bit 3 -> tx_out=1, busy=0 within the same cycle; next send of 0x55 transmits cleanly.
REQ-032 Single byte 0x41, PARITY=1 -> line 0,1,0,0,0,0,0,1,0,1,1; each bit 5208 cycles; done pulses once at cycle 57288 after accept.
REQ-033 Parity: 0x07 PARITY=1 -> parity bit 0; 0xFF PARITY=1 -> 1; 0xFF PARITY=0 -> 0; 0x00 PARITY=0 -> 0.
REQ-034 Back-to-back: send held high with din 0xA5 then 0x3C -> two frames, no gap between the first stop bit and the second start bit, two done pulses.
REQ-035 Busy-ignore: din changed to 0x00 and send pulsed during a 0xC3 frame -> 0xC3 transmitted, no second frame.
REQ-036 Loopback: tx_out into the team receiver model (same parameters), 256 random bytes -> every received byte matches and err stays 0.
